// File: rtl/io_timer.sv
// io_timer: memory-mapped interval timer on the CPU IO bus.
// Byte-lane register writes, countdown FSM and CP0 interrupt request.
package io_timer_pkg;
    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_SB   = 2'b01;
    localparam logic [1:0] BE_SH   = 2'b10;
    localparam logic [1:0] BE_SW   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } tmr_state_t;
endpackage

module io_timer
    import io_timer_pkg::*;
#(
    parameter logic [31:0] PRESET_RST     = 32'd0,
    parameter bit          IRQ_PULSE_AUTO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  addr,
    input  logic        io_we,
    input  logic [1:0]  be_op,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_pend;
    tmr_state_t  state;
    tmr_state_t  state_nx;

    logic [1:0]  sel;
    logic [3:0]  lanes;
    logic [31:0] lane_mask;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        en;
    logic        auto_mode;

    logic        hw_en_clr;
    logic        load_cnt;
    logic        dec_cnt;
    logic        zero_cnt;
    logic        pend_set;
    logic        pend_clr;

    assign sel       = addr[3:2];
    assign en        = ctrl[0];
    assign auto_mode = (ctrl[2:1] == 2'b01);

    // Misaligned or size-none accesses produce no lanes at all.
    always_comb begin
        lanes = 4'b0000;
        if (io_we) begin
            unique case (be_op)
                BE_SW: begin
                    if (addr[1:0] == 2'b00)
                        lanes = 4'b1111;
                end
                BE_SH: begin
                    if (!addr[0])
                        lanes = addr[1] ? 4'b1100 : 4'b0011;
                end
                BE_SB: begin
                    lanes = 4'b0001 << addr[1:0];
                end
                default: begin
                    lanes = 4'b0000;
                end
            endcase
        end
    end

    assign lane_mask = {{8{lanes[3]}}, {8{lanes[2]}},
                        {8{lanes[1]}}, {8{lanes[0]}}};

    assign wr_ctrl   = (sel == 2'd0) && (lanes != 4'b0000);
    assign wr_preset = (sel == 2'd1) && (lanes != 4'b0000);

    always_comb begin
        state_nx  = state;
        hw_en_clr = 1'b0;
        load_cnt  = 1'b0;
        dec_cnt   = 1'b0;
        zero_cnt  = 1'b0;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (en)
                    state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                load_cnt = 1'b1;
                state_nx = ST_CNT;
            end
            ST_CNT: begin
                if (!en) begin
                    state_nx = ST_IDLE;
                end else if (count > 32'd1) begin
                    dec_cnt = 1'b1;
                end else begin
                    zero_cnt = 1'b1;
                    pend_set = 1'b1;
                    state_nx = ST_INT;
                end
            end
            ST_INT: begin
                if (auto_mode) begin
                    pend_clr = IRQ_PULSE_AUTO;
                    state_nx = ST_LOAD;
                end else begin
                    hw_en_clr = 1'b1;
                    state_nx  = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // A software write to lane 0 overrides the one-shot EN clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ctrl <= 4'h0;
        else if (wr_ctrl && lanes[0])
            ctrl <= wdata[3:0];
        else if (hw_en_clr)
            ctrl[0] <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            preset <= PRESET_RST;
        else if (wr_preset)
            preset <= (preset & ~lane_mask) | (wdata & lane_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= 32'd0;
        else if (load_cnt)
            count <= preset;
        else if (dec_cnt)
            count <= count - 32'd1;
        else if (zero_cnt)
            count <= 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq_pend <= 1'b0;
        else if (wr_ctrl || wr_preset)
            irq_pend <= 1'b0;
        else if (pend_set)
            irq_pend <= 1'b1;
        else if (pend_clr)
            irq_pend <= 1'b0;
    end

    always_comb begin
        rdata = 32'd0;
        unique case (sel)
            2'd0:    rdata = {28'd0, ctrl};
            2'd1:    rdata = preset;
            2'd2:    rdata = count;
            default: rdata = 32'd0;
        endcase
    end

    assign irq = irq_pend & ctrl[3];

endmodule

// File: tb/tb_io_timer.sv
// Directed bench for io_timer: lane-decode table plus
// hand-timed countdown, auto-reload and reset sequences.
module tb_io_timer;
    localparam logic [1:0] SB = 2'b01;
    localparam logic [1:0] SH = 2'b10;
    localparam logic [1:0] SW = 2'b11;

    logic        clk;
    logic        rst_n;
    logic [3:0]  addr;
    logic        io_we;
    logic [1:0]  be_op;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int total;
    int passed;

    io_timer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .io_we (io_we),
        .be_op (be_op),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [3:0]  a;
        logic [1:0]  op;
        logic [31:0] d;
        logic [3:0]  ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] a);
        addr = a;
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [1:0] op,
                      input logic [31:0] d);
        addr  = a;
        be_op = op;
        wdata = d;
        io_we = 1'b1;
        step();
        io_we = 1'b0;
        be_op = 2'b00;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        addr   = 4'h0;
        io_we  = 1'b0;
        be_op  = 2'b00;
        wdata  = 32'd0;

        vecs[0]  = '{"sb_lane1",    1'b1, 4'h5, SB, 32'hAAAAAAAA, 4'h4, 32'h0000AA00};
        vecs[1]  = '{"sh_hi",       1'b1, 4'h6, SH, 32'h12341234, 4'h4, 32'h1234AA00};
        vecs[2]  = '{"sh_misalign", 1'b1, 4'h5, SH, 32'hFFFFFFFF, 4'h4, 32'h1234AA00};
        vecs[3]  = '{"sw_misalign", 1'b1, 4'h6, SW, 32'hFFFFFFFF, 4'h4, 32'h1234AA00};
        vecs[4]  = '{"be_none",     1'b1, 4'h4, 2'b00, 32'hFFFFFFFF, 4'h4, 32'h1234AA00};
        vecs[5]  = '{"we_low",      1'b0, 4'h4, SW, 32'hFFFFFFFF, 4'h4, 32'h1234AA00};
        vecs[6]  = '{"count_ro",    1'b1, 4'h8, SW, 32'hFFFFFFFF, 4'h8, 32'h00000000};
        vecs[7]  = '{"reserved",    1'b1, 4'hC, SW, 32'hFFFFFFFF, 4'hC, 32'h00000000};
        vecs[8]  = '{"ctrl_mask",   1'b1, 4'h0, SW, 32'hFFFFFFF6, 4'h0, 32'h00000006};
        vecs[9]  = '{"ctrl_lane3",  1'b1, 4'h3, SB, 32'hFFFFFFFF, 4'h0, 32'h00000006};
        vecs[10] = '{"sb_lane0",    1'b1, 4'h4, SB, 32'h55555555, 4'h4, 32'h1234AA55};
        vecs[11] = '{"sh_lo",       1'b1, 4'h4, SH, 32'hBEEFBEEF, 4'h4, 32'h1234BEEF};
        vecs[12] = '{"sb_lane3",    1'b1, 4'h7, SB, 32'h77777777, 4'h4, 32'h7734BEEF};
        vecs[13] = '{"sw_preset",   1'b1, 4'h4, SW, 32'h00000000, 4'h4, 32'h00000000};
        vecs[14] = '{"sw_ctrl",     1'b1, 4'h0, SW, 32'h00000000, 4'h0, 32'h00000000};

        repeat (2) @(posedge clk);
        #1;
        chk("irq_in_reset", {31'd0, irq}, 32'd0);
        #4;
        rst_n = 1'b1;
        step();
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rd(4'h0); chk("rst_ctrl", rdata, 32'd0);
        rd(4'h4); chk("rst_preset", rdata, 32'd0);
        rd(4'h8); chk("rst_count", rdata, 32'd0);
        rd(4'hC); chk("rst_rsvd", rdata, 32'd0);

        for (int i = 0; i < 15; i++) begin
            addr  = vecs[i].a;
            be_op = vecs[i].op;
            wdata = vecs[i].d;
            io_we = vecs[i].we;
            step();
            io_we = 1'b0;
            be_op = 2'b00;
            rd(vecs[i].ra);
            chk(vecs[i].name, rdata, vecs[i].exp);
        end

        // one-shot, PRESET=5, IM set
        wr(4'h4, SW, 32'd5);
        wr(4'h0, SW, 32'h9);
        step();
        rd(4'h8); chk("os_load_count", rdata, 32'd0);
        step();
        for (int k = 0; k <= 5; k++) begin
            rd(4'h8);
            chk($sformatf("os_count%0d", k), rdata, 32'(5 - k));
            chk($sformatf("os_irq%0d", k), {31'd0, irq}, {31'd0, k == 5});
            step();
        end
        rd(4'h0); chk("os_en_clr", rdata, 32'h8);
        chk("os_irq_hold0", {31'd0, irq}, 32'd1);
        step();
        step();
        chk("os_irq_hold1", {31'd0, irq}, 32'd1);
        rd(4'h8); chk("os_count_stay0", rdata, 32'd0);
        wr(4'h0, SW, 32'h8);
        chk("os_irq_swclr", {31'd0, irq}, 32'd0);

        // auto reload, PRESET=3: irq pulse every 5 cycles
        wr(4'h4, SW, 32'd3);
        wr(4'h0, SW, 32'hB);
        for (int c = 1; c <= 22; c++) begin
            step();
            if (c >= 2) begin
                rd(4'h8);
                chk($sformatf("ar_count_c%0d", c), rdata,
                    ((c - 2) % 5 <= 3) ? 32'(3 - (c - 2) % 5) : 32'd0);
            end
            chk($sformatf("ar_irq_c%0d", c), {31'd0, irq},
                {31'd0, (c >= 5) && ((c - 5) % 5 == 0)});
        end
        wr(4'h0, SW, 32'h0);
        repeat (6) step();

        // mid-count disable / re-enable, PRESET=10
        wr(4'h4, SW, 32'd10);
        wr(4'h0, SW, 32'h1);
        repeat (5) step();
        rd(4'h8); chk("mc_count7", rdata, 32'd7);
        wr(4'h0, SW, 32'h0);
        rd(4'h8); chk("mc_count6", rdata, 32'd6);
        for (int k = 0; k < 3; k++) begin
            step();
            rd(4'h8); chk($sformatf("mc_freeze%0d", k), rdata, 32'd6);
        end
        wr(4'h0, SW, 32'h1);
        rd(4'h8); chk("mc_reen_idle", rdata, 32'd6);
        step();
        rd(4'h8); chk("mc_reen_load", rdata, 32'd6);
        step();
        rd(4'h8); chk("mc_reload", rdata, 32'd10);
        wr(4'h4, SW, 32'd100);
        rd(4'h8); chk("mc_pre_wr_cnt", rdata, 32'd9);
        rd(4'h4); chk("mc_pre_val", rdata, 32'd100);
        step();
        rd(4'h8); chk("mc_cnt8", rdata, 32'd8);
        wr(4'h0, SW, 32'h1);
        rd(4'h8); chk("mc_en_again", rdata, 32'd7);
        step();
        rd(4'h8); chk("mc_no_restart", rdata, 32'd6);
        wr(4'h0, SW, 32'h0);
        repeat (3) step();

        // PRESET=0, IM=0: pending set but masked, then IM write clears it
        wr(4'h4, SW, 32'd0);
        wr(4'h0, SW, 32'h1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("p0_irq%0d", k), {31'd0, irq}, 32'd0);
        end
        rd(4'h0); chk("p0_en_clr", rdata, 32'h0);
        rd(4'h8); chk("p0_count", rdata, 32'd0);
        wr(4'h0, SB, 32'h08080808);
        rd(4'h0); chk("p0_im_set", rdata, 32'h8);
        chk("p0_irq_after_im", {31'd0, irq}, 32'd0);
        step();
        chk("p0_irq_later", {31'd0, irq}, 32'd0);

        // asynchronous reset mid-count
        wr(4'h4, SW, 32'd20);
        wr(4'h0, SW, 32'h9);
        repeat (4) step();
        rd(4'h8); chk("ar_pre_count", rdata, 32'd18);
        #5;
        rst_n = 1'b0;
        #1;
        chk("arst_irq", {31'd0, irq}, 32'd0);
        rd(4'h8); chk("arst_count", rdata, 32'd0);
        rd(4'h0); chk("arst_ctrl", rdata, 32'd0);
        rd(4'h4); chk("arst_preset", rdata, 32'd0);
        @(posedge clk);
        #5;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            rd(4'h8); chk($sformatf("post_rst_count%0d", k), rdata, 32'd0);
            chk($sformatf("post_rst_irq%0d", k), {31'd0, irq}, 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
